instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Instruction-fetch stage of the pipelined 64-bit CPU. It sits directly upstream of the IF/ID pipeline register and owns the fetch PC. It issues one word request at a time to instruction memory and holds the returned instruction with its PC in a one-entry output slot (IFPC/IFInst/IFValid) until the IF/ID register captures it. It obeys hazard-unit stalls and branch redirects from later stages.

## Interface
- RESET_PC, 64'h0, fetch address of the first instruction after reset release

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = in reset)
- stall  in  1  hazard unit: IF/ID will not capture this cycle
- redirect  in  1  branch taken / flush from later stage
- redirect_pc  in  64  new fetch address; bits [1:0] forced to 0
- imem_req  out  1  fetch request valid
- imem_addr  out  64  fetch address (word aligned)
- imem_ready  in  1  memory accepts request this cycle
- imem_rvalid  in  1  response data valid
- imem_rdata  in  32  instruction word
- IFPC  out  64  PC of held instruction
- IFInst  out  32  held instruction
- IFValid  out  1  slot holds a valid instruction

## Operation
- Registers: pc (next fetch address), req_pc (address of outstanding request), state, output slot.
- States:
  - FETCH: may issue a request.
  - WAIT: one request outstanding.
  - DROP: one request outstanding whose response must be discarded.
- imem_req = (state==FETCH) && !redirect && (!IFValid || !stall); imem_addr = pc.
- Handshake: imem_req && imem_ready at an edge → req_pc <= pc, state <= WAIT.
- WAIT, imem_rvalid, no redirect:
  - slot <= {req_pc, imem_rdata, 1}
  - pc <= req_pc + 4, modulo 2^64 (wraps to 0)
  - state <= FETCH
- Slot consumption: at an edge with IFValid && !stall && !redirect, IFValid <= 0 and IFPC/IFInst <= 0, unless refilled at the same edge.
- Invariant: the slot is empty whenever state is WAIT. The request gating guarantees this; the bench asserts it.
- Redirect has the highest priority at every edge:
  - pc <= {redirect_pc[63:2], 2'b00}
  - slot cleared (IFValid = 0, IFPC = 0, IFInst = 0)
  - FETCH → FETCH (no request is issued in the redirect cycle)
  - WAIT with imem_rvalid at the same edge → data discarded, FETCH
  - WAIT without imem_rvalid → DROP
  - DROP → DROP; pc is updated again and the latest redirect wins
- DROP, imem_rvalid, no redirect: data discarded, state <= FETCH, pc unchanged.
- imem_rvalid in FETCH is ignored.
- stall does not affect an outstanding request. The response still fills the empty slot and is then held while stall=1.

## Timing
- Reset (asynchronous, reset=0), outputs settle immediately without a clock edge:
  - state = FETCH, pc = RESET_PC, req_pc = 0
  - IFValid = 0, IFPC = 0, IFInst = 0, imem_req = 0
- The first request is asserted in the first cycle after reset rises (combinationally from FETCH).
- Reset while in WAIT/DROP abandons the request. Instruction memory is reset by the same signal, so no stale response is expected; any stale response arrives in FETCH and is ignored.
- imem_ready is sampled in the same cycle as imem_req. Requests are not pipelined (at most one outstanding).
- imem_rvalid arrives no earlier than the cycle after acceptance.
- Latency: the slot is valid the cycle after the imem_rvalid cycle.
- Peak throughput, with ready=1 and rvalid one cycle after acceptance: one instruction every 2 cycles.
- The slot value is stable for the whole time IFValid=1 and stall=1.
- All outputs are registered except imem_req and imem_addr.

## Test plan
1. Reset release, RESET_PC=0, ready=1, rvalid one cycle after acceptance, rdata=addr+0xA0 → imem_addr 0,4,8; IFPC/IFInst = 0/0xA0, 4/0xA4, 8/0xA8, with IFValid=1 every 2nd cycle.
2. Slot holds IFPC=8; stall=1 for 3 cycles → IFPC=8, IFInst=0xA8 held and imem_req=0 throughout; after stall drops, the next fetch is at 0xC.
3. Redirect to 0x100 while in WAIT for 0x10 → slot cleared; the next rvalid (0xB0) is dropped; next imem_addr=0x100; IFPC=0x100 is delivered.
4. Redirect to 0x203 in the same cycle as rvalid in WAIT → data discarded, no DROP state; next imem_addr=0x200; two redirects in DROP (0x300, then 0x400) → the fetch goes to 0x400.
5. RESET_PC=0xFFFF_FFFF_FFFF_FFFC → first IFPC=0xFFFF_FFFF_FFFF_FFFC, next imem_addr=0.
6. reset=0 asserted mid-WAIT between clock edges → IFValid/IFPC/IFInst/imem_req go to 0 immediately; a stray rvalid after release is ignored; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_if.sv
// Instruction-memory request/response channel between the fetch stage and imem.
// Ports: imem_req/imem_addr (request, fetch side drives), imem_ready (accept),
//        imem_rvalid/imem_rdata (response, one word per accepted request).
interface instruction_fetch_if;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues one imem word request at a time, holds the reply in a one-entry slot.
// Latency: slot valid the cycle after imem_rvalid; peak one instruction per 2 cycles.
// Backpressure: stall holds a full slot and blocks new requests; an outstanding request still completes.
// Ports: clk, reset (async, active low), stall, redirect/redirect_pc (flush + new PC),
//        imem (master side of instruction_fetch_if), IFPC/IFInst/IFValid (registered output slot).
module instruction_fetch #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       stall,
    input  logic                       redirect,
    input  logic [63:0]                redirect_pc,
    instruction_fetch_if.master        imem,
    output logic [63:0]                IFPC,
    output logic [31:0]                IFInst,
    output logic                       IFValid
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DROP  = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [63:0] pc, pc_nxt;
    logic [63:0] req_pc, req_pc_nxt;
    logic [63:0] ifpc_nxt;
    logic [31:0] ifinst_nxt;
    logic        ifvalid_nxt;
    logic [63:0] redirect_aligned;

    assign redirect_aligned = redirect_pc & ~64'h3;

    // A new request is only issued when its reply is guaranteed a free slot:
    // either the slot is empty or it is being consumed this very edge.
    assign imem.imem_req  = reset && (state == FETCH) && !redirect && (!IFValid || !stall);
    assign imem.imem_addr = pc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        req_pc_nxt  = req_pc;
        ifpc_nxt    = IFPC;
        ifinst_nxt  = IFInst;
        ifvalid_nxt = IFValid;

        if (IFValid && !stall) begin
            ifvalid_nxt = 1'b0;
            ifpc_nxt    = 64'h0;
            ifinst_nxt  = 32'h0;
        end

        if (redirect) begin
            pc_nxt      = redirect_aligned;
            ifvalid_nxt = 1'b0;
            ifpc_nxt    = 64'h0;
            ifinst_nxt  = 32'h0;
            // A reply arriving on the redirect edge closes the request; otherwise
            // the in-flight reply still has to be swallowed later.
            case (state)
                WAIT, DROP: state_nxt = imem.imem_rvalid ? FETCH : DROP;
                default:    state_nxt = FETCH;
            endcase
        end else begin
            case (state)
                FETCH: begin
                    if (imem.imem_req && imem.imem_ready) begin
                        req_pc_nxt = pc;
                        state_nxt  = WAIT;
                    end
                end
                WAIT: begin
                    if (imem.imem_rvalid) begin
                        ifvalid_nxt = 1'b1;
                        ifpc_nxt    = req_pc;
                        ifinst_nxt  = imem.imem_rdata;
                        pc_nxt      = req_pc + 64'd4;
                        state_nxt   = FETCH;
                    end
                end
                DROP: begin
                    if (imem.imem_rvalid) begin
                        state_nxt = FETCH;
                    end
                end
                default: state_nxt = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc      <= RESET_PC;
            req_pc  <= 64'h0;
            IFPC    <= 64'h0;
            IFInst  <= 32'h0;
            IFValid <= 1'b0;
        end else begin
            pc      <= pc_nxt;
            req_pc  <= req_pc_nxt;
            IFPC    <= ifpc_nxt;
            IFInst  <= ifinst_nxt;
            IFValid <= ifvalid_nxt;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

    localparam logic [63:0] HI_RESET_PC = 64'hFFFF_FFFF_FFFF_FFFC;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic [63:0] IFPC;
    logic [31:0] IFInst;
    logic        IFValid;
    logic [63:0] hi_ifpc;
    logic [31:0] hi_ifinst;
    logic        hi_ifvalid;

    instruction_fetch_if mif ();
    instruction_fetch_if hi_if ();

    instruction_fetch #(.RESET_PC(64'h0)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem        (mif),
        .IFPC        (IFPC),
        .IFInst      (IFInst),
        .IFValid     (IFValid)
    );

    // Second instance only used to observe wrap-around from a top-of-memory reset PC.
    instruction_fetch #(.RESET_PC(HI_RESET_PC)) u_dut_hi (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem        (hi_if),
        .IFPC        (hi_ifpc),
        .IFInst      (hi_ifinst),
        .IFValid     (hi_ifvalid)
    );

    assign hi_if.imem_ready  = mif.imem_ready;
    assign hi_if.imem_rvalid = mif.imem_rvalid;
    assign hi_if.imem_rdata  = 32'hC0DE_0000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: architectural view of the fetch stage plus the memory's
    // single outstanding transaction.
    logic [63:0] m_pc;
    logic        m_vld;
    logic [63:0] m_ifpc;
    logic [31:0] m_inst;
    logic        mem_busy;
    logic        mem_discard;
    logic [63:0] mem_addr;
    int          mem_cnt;
    logic        stray;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc        = 64'h0;
        m_vld       = 1'b0;
        m_ifpc      = 64'h0;
        m_inst      = 32'h0;
        mem_busy    = 1'b0;
        mem_discard = 1'b0;
        mem_addr    = 64'h0;
        mem_cnt     = 0;
    endtask

    // Reset asserted mid-cycle; outputs must clear without waiting for an edge.
    task automatic apply_reset(input logic with_stray);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_IFValid", 64'(IFValid), 64'h0);
        chk("rst_IFPC", IFPC, 64'h0);
        chk("rst_IFInst", 64'(IFInst), 64'h0);
        chk("rst_imem_req", 64'(mif.imem_req), 64'h0);
        model_reset();
        stall           = 1'b0;
        redirect        = 1'b0;
        redirect_pc     = 64'h0;
        mif.imem_ready  = 1'b0;
        mif.imem_rvalid = 1'b0;
        mif.imem_rdata  = 32'h0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("post_rst_req", 64'(mif.imem_req), 64'h1);
        chk("post_rst_addr", mif.imem_addr, 64'h0);
        chk("hi_post_rst_addr", hi_if.imem_addr, HI_RESET_PC);
        stray = with_stray;
    endtask

    // One clock cycle: check registered outputs, drive inputs, check the
    // combinational request, then advance the model across the coming edge.
    task automatic cycle(input logic st, input logic rd, input logic [63:0] rpc,
                         input logic rdy, input int lat);
        logic rv;
        logic live_rv;
        logic exp_req;
        logic acc;
        @(negedge clk);
        chk("IFValid", 64'(IFValid), 64'(m_vld));
        chk("IFPC", IFPC, m_ifpc);
        chk("IFInst", 64'(IFInst), 64'(m_inst));
        if (mem_busy) chk("slot_empty_while_outstanding", 64'(IFValid), 64'h0);

        live_rv         = mem_busy && (mem_cnt == 0);
        rv              = live_rv || stray;
        stall           = st;
        redirect        = rd;
        redirect_pc     = rpc;
        mif.imem_ready  = rdy;
        mif.imem_rvalid = rv;
        mif.imem_rdata  = live_rv ? (mem_addr[31:0] + 32'hA0) : 32'($urandom);
        #1;
        exp_req = !mem_busy && !rd && (!m_vld || !st);
        chk("imem_req", 64'(mif.imem_req), 64'(exp_req));
        if (exp_req) chk("imem_addr", mif.imem_addr, m_pc);

        acc = 1'b0;
        if (m_vld && !st) begin
            m_vld  = 1'b0;
            m_ifpc = 64'h0;
            m_inst = 32'h0;
        end
        if (rd) begin
            m_pc   = {rpc[63:2], 2'b00};
            m_vld  = 1'b0;
            m_ifpc = 64'h0;
            m_inst = 32'h0;
            if (live_rv) begin
                mem_busy    = 1'b0;
                mem_discard = 1'b0;
            end else if (mem_busy) begin
                mem_discard = 1'b1;
            end
        end else if (live_rv) begin
            mem_busy = 1'b0;
            if (!mem_discard) begin
                m_vld  = 1'b1;
                m_ifpc = mem_addr;
                m_inst = mem_addr[31:0] + 32'hA0;
                m_pc   = mem_addr + 64'd4;
            end
            mem_discard = 1'b0;
        end else if (exp_req && rdy) begin
            mem_busy    = 1'b1;
            mem_addr    = m_pc;
            mem_cnt     = lat - 1;
            mem_discard = 1'b0;
            acc         = 1'b1;
        end
        if (mem_busy && !acc && mem_cnt > 0) mem_cnt--;
        stray = 1'b0;
    endtask

    initial begin
        logic [63:0] rpc;
        reset           = 1'b0;
        stall           = 1'b0;
        redirect        = 1'b0;
        redirect_pc     = 64'h0;
        mif.imem_ready  = 1'b0;
        mif.imem_rvalid = 1'b0;
        mif.imem_rdata  = 32'h0;
        stray           = 1'b0;
        model_reset();

        // Streaming fetch 0,4,8 with single-cycle memory.
        apply_reset(1'b0);
        repeat (3) cycle(1'b0, 1'b0, 64'h0, 1'b1, 1);
        chk("hi_first_IFPC", hi_ifpc, HI_RESET_PC);
        chk("hi_first_IFInst", 64'(hi_ifinst), 64'hC0DE_0000);
        chk("hi_wrap_req", 64'(hi_if.imem_req), 64'h1);
        chk("hi_wrap_addr", hi_if.imem_addr, 64'h0);
        repeat (3) cycle(1'b0, 1'b0, 64'h0, 1'b1, 1);

        // Stall holds slot PC 8, then fetch resumes at 0xC.
        repeat (3) cycle(1'b1, 1'b0, 64'h0, 1'b1, 1);
        repeat (2) cycle(1'b0, 1'b0, 64'h0, 1'b1, 1);

        // Redirect while waiting for 0x10: reply dropped, fetch 0x100.
        cycle(1'b0, 1'b0, 64'h0, 1'b1, 2);
        cycle(1'b0, 1'b1, 64'h100, 1'b1, 1);
        repeat (4) cycle(1'b0, 1'b0, 64'h0, 1'b1, 1);

        // Redirect coinciding with reply, then two redirects while dropping.
        cycle(1'b0, 1'b1, 64'h203, 1'b1, 1);
        cycle(1'b0, 1'b0, 64'h0, 1'b1, 3);
        cycle(1'b0, 1'b1, 64'h300, 1'b1, 1);
        cycle(1'b0, 1'b1, 64'h400, 1'b1, 1);
        repeat (4) cycle(1'b0, 1'b0, 64'h0, 1'b1, 1);

        // Wrap via redirect to the top word.
        cycle(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1);
        repeat (4) cycle(1'b0, 1'b0, 64'h0, 1'b1, 1);

        // Reset in the middle of a pending request, then a stray reply.
        cycle(1'b0, 1'b0, 64'h0, 1'b1, 4);
        cycle(1'b0, 1'b0, 64'h0, 1'b1, 1);
        apply_reset(1'b1);
        repeat (4) cycle(1'b0, 1'b0, 64'h0, 1'b1, 1);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            if (i % 900 == 899) apply_reset($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 3) == 0)
                rpc = {56'hFF_FFFF_FFFF_FFFF, 8'($urandom)};
            else
                rpc = {32'($urandom), 32'($urandom)};
            cycle($urandom_range(0, 9) < 3, $urandom_range(0, 99) < 8, rpc,
                  $urandom_range(0, 9) < 7, int'($urandom_range(1, 4)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
